// File: rtl/lfsr_pkg.sv
// Shared XNOR-LFSR definitions used by the pattern generator and by the sequence checker.
package lfsr_pkg;

  localparam int MAX_BITS = 8;

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_SYNC   = 2'd1;
  localparam logic [1:0] ST_LOCKED = 2'd2;

  // Tap mask, right-aligned: bit num_bits-1 is the MSB of the LFSR word.
  function automatic logic [MAX_BITS-1:0] lfsr_taps(input int num_bits);
    case (num_bits)
      3:       return 8'b0000_0110;
      4:       return 8'b0000_1100;
      5:       return 8'b0001_0100;
      6:       return 8'b0011_0000;
      7:       return 8'b0110_0000;
      8:       return 8'b1011_1000;
      default: return 8'b0000_0000;
    endcase
  endfunction

  function automatic logic [MAX_BITS-1:0] lfsr_next(input logic [MAX_BITS-1:0] d,
                                                    input int num_bits);
    logic [MAX_BITS-1:0] mask;
    logic                fb;
    mask = 8'((1 << num_bits) - 1);
    fb   = ~^(d & lfsr_taps(num_bits));
    return ((d << 1) | {7'b000_0000, fb}) & mask;
  endfunction

endpackage

// File: rtl/lfsr_period_meter.sv
// Counts valid words between successive done pulses and reports the done-to-done period.
module lfsr_period_meter #(
  parameter int CNT_W = 5
) (
  input  logic             i_Clk,
  input  logic             i_Rst_L,
  input  logic             i_Clear,
  input  logic             i_Valid,
  input  logic             i_Done,
  output logic [CNT_W-1:0] o_Period,
  output logic             o_Period_DV
);

  logic             armed_reg;
  logic [CNT_W-1:0] count_reg;
  logic [CNT_W-1:0] period_reg;
  logic             period_dv_reg;
  logic [CNT_W-1:0] count_sat;

  assign count_sat = (count_reg == '1) ? count_reg : count_reg + 1'b1;

  always_ff @(posedge i_Clk) begin
    if (!i_Rst_L) begin
      armed_reg     <= 1'b0;
      count_reg     <= '0;
      period_reg    <= '0;
      period_dv_reg <= 1'b0;
    end else begin
      period_dv_reg <= 1'b0;
      if (i_Clear) begin
        // A clear coinciding with done disarms and suppresses the update.
        armed_reg <= 1'b0;
        count_reg <= '0;
      end else if (i_Valid) begin
        if (i_Done) begin
          count_reg <= '0;
          armed_reg <= 1'b1;
          if (armed_reg) begin
            period_reg    <= count_sat;
            period_dv_reg <= 1'b1;
          end
        end else begin
          count_reg <= count_sat;
        end
      end
    end
  end

  assign o_Period    = period_reg;
  assign o_Period_DV = period_dv_reg;

endmodule

// File: rtl/lfsr_seq_checker.sv
// Self-synchronising checker for an XNOR LFSR word stream: lock tracking, error pulses/count, period.
module lfsr_seq_checker
  import lfsr_pkg::*;
#(
  parameter int NUM_BITS   = 4,
  parameter int LOCK_COUNT = 4,
  parameter int LOSS_COUNT = 3,
  parameter int ERR_W      = 16
) (
  input  logic                i_Clk,
  input  logic                i_Rst_L,
  input  logic                i_Data_DV,
  input  logic [NUM_BITS-1:0] i_Data,
  input  logic                i_Done,
  input  logic                i_Clear,
  output logic                o_Locked,
  output logic                o_Error,
  output logic [ERR_W-1:0]    o_Err_Count,
  output logic [NUM_BITS:0]   o_Period,
  output logic                o_Period_DV
);

  if (NUM_BITS < 3 || NUM_BITS > 8) begin : g_bad_num_bits
    $error("lfsr_seq_checker: NUM_BITS must be in 3..8");
  end

  localparam int MATCH_W = $clog2(LOCK_COUNT + 1);
  localparam int MISS_W  = $clog2(LOSS_COUNT + 1);

  function automatic logic [NUM_BITS-1:0] next_word(input logic [NUM_BITS-1:0] d);
    return NUM_BITS'(lfsr_next(8'(d), NUM_BITS));
  endfunction

  logic [1:0]          state_reg, state_next;
  logic [NUM_BITS-1:0] expected_reg, expected_next;
  logic [MATCH_W-1:0]  match_cnt_reg, match_cnt_next;
  logic [MISS_W-1:0]   miss_cnt_reg, miss_cnt_next;
  logic [ERR_W-1:0]    err_count_reg, err_count_next;
  logic                error_reg, error_next;
  logic                word_match;

  assign word_match = (i_Data == expected_reg);

  always_comb begin
    state_next     = state_reg;
    expected_next  = expected_reg;
    match_cnt_next = match_cnt_reg;
    miss_cnt_next  = miss_cnt_reg;
    err_count_next = err_count_reg;
    error_next     = 1'b0;
    if (i_Data_DV) begin
      case (state_reg)
        ST_IDLE: begin
          expected_next  = next_word(i_Data);
          match_cnt_next = '0;
          state_next     = ST_SYNC;
        end
        ST_SYNC: begin
          if (word_match) begin
            expected_next = next_word(expected_reg);
            if (int'(match_cnt_reg) + 1 >= LOCK_COUNT) begin
              state_next     = ST_LOCKED;
              match_cnt_next = '0;
              miss_cnt_next  = '0;
            end else begin
              match_cnt_next = match_cnt_reg + 1'b1;
            end
          end else begin
            expected_next  = next_word(i_Data);
            match_cnt_next = '0;
          end
        end
        ST_LOCKED: begin
          // Free-run on the prediction so one bad word does not derail the sequence.
          expected_next = next_word(expected_reg);
          if (word_match) begin
            miss_cnt_next = '0;
          end else begin
            error_next = 1'b1;
            if (err_count_reg != '1) err_count_next = err_count_reg + 1'b1;
            if (int'(miss_cnt_reg) + 1 >= LOSS_COUNT) begin
              state_next     = ST_SYNC;
              expected_next  = next_word(i_Data);
              match_cnt_next = '0;
              miss_cnt_next  = '0;
            end else begin
              miss_cnt_next = miss_cnt_reg + 1'b1;
            end
          end
        end
        default: state_next = ST_IDLE;
      endcase
    end
    if (i_Clear) err_count_next = '0;
  end

  always_ff @(posedge i_Clk) begin
    if (!i_Rst_L) begin
      state_reg     <= ST_IDLE;
      expected_reg  <= '0;
      match_cnt_reg <= '0;
      miss_cnt_reg  <= '0;
      err_count_reg <= '0;
      error_reg     <= 1'b0;
    end else begin
      state_reg     <= state_next;
      expected_reg  <= expected_next;
      match_cnt_reg <= match_cnt_next;
      miss_cnt_reg  <= miss_cnt_next;
      err_count_reg <= err_count_next;
      error_reg     <= error_next;
    end
  end

  lfsr_period_meter #(
    .CNT_W(NUM_BITS + 1)
  ) u_period_meter (
    .i_Clk      (i_Clk),
    .i_Rst_L    (i_Rst_L),
    .i_Clear    (i_Clear),
    .i_Valid    (i_Data_DV),
    .i_Done     (i_Done),
    .o_Period   (o_Period),
    .o_Period_DV(o_Period_DV)
  );

  assign o_Locked    = (state_reg == ST_LOCKED);
  assign o_Error     = error_reg;
  assign o_Err_Count = err_count_reg;

endmodule

// File: tb/tb_lfsr_seq_checker.sv
// Directed bench for lfsr_seq_checker: lock, errors, loss/relock, period, reset and saturation.
module tb_lfsr_seq_checker;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       dv = 1'b0;
  logic [3:0] data = 4'h0;
  logic       done = 1'b0;
  logic       clear = 1'b0;

  logic        locked, error, period_dv;
  logic [15:0] err_count;
  logic [4:0]  period;
  logic        s_locked, s_error, s_period_dv;
  logic [1:0]  s_err_count;
  logic [4:0]  s_period;

  int checks = 0;
  int errors = 0;
  int idx = 0;
  logic [3:0] seq [15];

  logic mon_en = 1'b0;
  int   dv_pulses = 0;
  int   lock_drops = 0;

  always #5 clk = ~clk;

  lfsr_seq_checker #(.NUM_BITS(4), .LOCK_COUNT(4), .LOSS_COUNT(3), .ERR_W(16)) dut (
    .i_Clk(clk), .i_Rst_L(rst_n), .i_Data_DV(dv), .i_Data(data), .i_Done(done),
    .i_Clear(clear), .o_Locked(locked), .o_Error(error), .o_Err_Count(err_count),
    .o_Period(period), .o_Period_DV(period_dv)
  );

  lfsr_seq_checker #(.NUM_BITS(4), .LOCK_COUNT(4), .LOSS_COUNT(3), .ERR_W(2)) dut_sat (
    .i_Clk(clk), .i_Rst_L(rst_n), .i_Data_DV(dv), .i_Data(data), .i_Done(done),
    .i_Clear(clear), .o_Locked(s_locked), .o_Error(s_error), .o_Err_Count(s_err_count),
    .o_Period(s_period), .o_Period_DV(s_period_dv)
  );

  always @(negedge clk) begin
    if (mon_en) begin
      if (period_dv) dv_pulses++;
      if (!locked) lock_drops++;
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic send(input logic [3:0] d, input logic dn, input logic clr);
    @(negedge clk);
    data  = d;
    dv    = 1'b1;
    done  = dn;
    clear = clr;
    @(posedge clk);
    #1;
    $display("word %h done=%0b clear=%0b -> locked=%0b error=%0b cnt=%0d period=%0d pdv=%0b",
             d, dn, clr, locked, error, err_count, period, period_dv);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      dv    = 1'b0;
      done  = 1'b0;
      clear = 1'b0;
      @(posedge clk);
      #1;
    end
  endtask

  task automatic send_true(input logic clr);
    send(seq[idx], 1'b0, clr);
    idx = (idx + 1) % 15;
  endtask

  task automatic send_bad(input logic clr);
    send(seq[idx] ^ 4'hF, 1'b0, clr);
    idx = (idx + 1) % 15;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL timeout reached");
    $fatal(1, "timeout");
  end

  initial begin
    seq = '{4'h0, 4'h1, 4'h3, 4'h7, 4'hE, 4'hD, 4'hB, 4'h6,
            4'hC, 4'h9, 4'h2, 4'h5, 4'hA, 4'h4, 4'h8};

    // Reset state
    idle(2);
    check("rst_locked", locked, 0);
    check("rst_error", error, 0);
    check("rst_err_count", err_count, 0);
    check("rst_period", period, 0);
    check("rst_period_dv", period_dv, 0);
    rst_n = 1'b1;
    idle(1);

    // Acquire lock: seed word plus four matches
    repeat (4) send_true(1'b0);
    check("t1_not_locked_4", locked, 0);
    send_true(1'b0);
    check("t1_locked_5", locked, 1);
    check("t1_no_error", error, 0);
    check("t1_err_count", err_count, 0);
    send_true(1'b0);

    // Single corrupted word while locked (1011 replaced)
    send_bad(1'b0);
    check("t2_error_pulse", error, 1);
    check("t2_err_count", err_count, 1);
    check("t2_still_locked", locked, 1);
    send_true(1'b0);
    check("t2_error_cleared", error, 0);
    send_true(1'b0);
    send_true(1'b0);
    check("t2_no_more_errors", err_count, 1);
    check("t2_locked_after", locked, 1);

    // Three consecutive misses drop lock, then relock
    send_bad(1'b0);
    check("t3_cnt_after_1", err_count, 2);
    check("t3_locked_after_1", locked, 1);
    send_bad(1'b0);
    check("t3_locked_after_2", locked, 1);
    send_bad(1'b0);
    check("t3_cnt_after_3", err_count, 4);
    check("t3_error_3", error, 1);
    check("t3_unlocked", locked, 0);
    send_true(1'b0);
    check("t3_sync_no_error", error, 0);
    check("t3_sync_no_count", err_count, 4);
    repeat (3) send_true(1'b0);
    check("t3_not_yet_relocked", locked, 0);
    send_true(1'b0);
    check("t3_relocked", locked, 1);

    // Period measurement with random DV gaps, done on every 0000
    mon_en = 1'b1;
    while (idx != 0) begin
      send_true(1'b0);
      idle($urandom_range(0, 3));
    end
    send(seq[0], 1'b1, 1'b0);
    idx = 1;
    check("t4_first_done_arms_only", period_dv, 0);
    check("t4_period_still_0", period, 0);
    for (int p = 0; p < 2; p++) begin
      idle($urandom_range(0, 3));
      for (int k = 0; k < 14; k++) begin
        send_true(1'b0);
        idle($urandom_range(0, 3));
      end
      send(seq[0], 1'b1, 1'b0);
      idx = 1;
      check("t4_period_dv", period_dv, 1);
      check("t4_period_15", period, 15);
    end
    idle(1);
    mon_en = 1'b0;
    check("t4_dv_dropped", period_dv, 0);
    check("t4_dv_pulses", dv_pulses, 2);
    check("t4_lock_drops", lock_drops, 0);

    // Clear keeps lock, then two spaced errors and a mid-stream reset
    send_true(1'b1);
    check("t5_clear_count", err_count, 0);
    check("t5_clear_keeps_lock", locked, 1);
    send_bad(1'b0);
    send_true(1'b0);
    send_bad(1'b0);
    send_true(1'b0);
    check("t5_err_count_2", err_count, 2);
    check("t5_locked_2", locked, 1);
    rst_n = 1'b0;
    send_true(1'b0);
    rst_n = 1'b1;
    check("t5_rst_locked", locked, 0);
    check("t5_rst_error", error, 0);
    check("t5_rst_err_count", err_count, 0);
    check("t5_rst_period", period, 0);
    check("t5_rst_period_dv", period_dv, 0);
    repeat (4) send_true(1'b0);
    check("t5_relock_not_4", locked, 0);
    send_true(1'b0);
    check("t5_relock_5", locked, 1);

    // Saturation of a 2-bit error counter while lock is held
    send_bad(1'b0);
    send_true(1'b0);
    send_bad(1'b0);
    send_true(1'b0);
    send_bad(1'b0);
    send_true(1'b0);
    check("t6_sat_reach_3", s_err_count, 3);
    send_bad(1'b0);
    check("t6_sat_hold_3", s_err_count, 3);
    check("t6_sat_error", s_error, 1);
    check("t6_sat_locked", s_locked, 1);
    check("t6_wide_count_4", err_count, 4);
    send_true(1'b0);
    send_true(1'b1);
    check("t6_sat_cleared", s_err_count, 0);
    check("t6_sat_locked_after_clear", s_locked, 1);
    check("t6_wide_cleared", err_count, 0);
    send_bad(1'b1);
    check("t6_clear_vs_miss_count", err_count, 0);
    check("t6_clear_vs_miss_error", error, 1);
    send_true(1'b0);
    check("t6_final_error", error, 0);
    check("t6_final_locked", locked, 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
